// File: rtl/rr_ring_arbiter_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin ring arbiter.
// One-hot helpers work on a 16-bit container, the largest supported N.
package rr_arb_pkg;

  localparam int MAXN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index of the set bit of a one-hot vector (0 if none).
  function automatic logic [3:0] onehot_to_idx(
    input logic [MAXN-1:0] v
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Rotate a one-hot vector up by one, wrapping bit n-1 to bit 0.
  function automatic logic [MAXN-1:0] rotl1(
    input logic [MAXN-1:0] v,
    input int              n
  );
    logic [MAXN-1:0] r;
    r = v << 1;
    if (v[n-1]) r = MAXN'(1);
    return r;
  endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// rr_ring_arbiter_if: request/grant bundle between engines and arbiter.
// master = requester side, slave = arbiter side.
interface rr_ring_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic [N-1:0]  ptr;
  logic          timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  ptr,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output ptr,
    output timeout
  );
endinterface

// File: rtl/rr_ring_arbiter_pick.sv
// rr_pick: wrap-around priority scan starting at the pointer bit.
// Purely combinational; first requester at or above ptr wins.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  ptr,
  output logic          win_valid,
  output logic [IW-1:0] win_idx
);

  int p;
  int j;

  // Scan N slots upward from the pointer index, wrapping at N.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    j         = 0;
    p         = int'(onehot_to_idx(MAXN'(ptr)));
    for (int k = 0; k < N; k++) begin
      j = p + k;
      if (j >= N) j = j - N;
      if (!win_valid && req[j]) begin
        win_valid = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with hold limit and turnaround gap.
// Registered grant outputs; ring pointer rotates past each released owner.
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  rr_ring_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t        state_q, state_n;
  logic [N-1:0]  gnt_q, gnt_n;
  logic [IW-1:0] id_q, id_n;
  logic [N-1:0]  ptr_q, ptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          to_q, to_n;
  logic          vld_q;

  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          owner_req;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  assign owner_req = bus.req[id_q];

  // Next-state, grant and pointer update.
  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    id_n    = id_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    to_n    = 1'b0;
    unique case (state_q)
      GRANT: begin
        if (!owner_req) begin
          state_n = GAP;
          gnt_n   = '0;
          id_n    = '0;
          cnt_n   = '0;
          ptr_n   = N'(rotl1(MAXN'(gnt_q), N));
        end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          state_n = GAP;
          gnt_n   = '0;
          id_n    = '0;
          cnt_n   = '0;
          to_n    = 1'b1;
          ptr_n   = N'(rotl1(MAXN'(gnt_q), N));
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_n = '0;
        if (win_valid) begin
          state_n = GRANT;
          gnt_n   = N'(1) << win_idx;
          id_n    = win_idx;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
        end
      end
    endcase
  end

  // State and output registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= N'(1);
      cnt_q   <= '0;
      to_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      id_q    <= id_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      to_q    <= to_n;
      vld_q   <= |gnt_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.gnt_id    = id_q;
  assign bus.ptr       = ptr_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb_rr_ring_arbiter: scoreboard bench with a tenure-level reference model.
// Model predicts outputs at each edge; monitor compares on the falling edge.
module tb_rr_ring_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [N-1:0] gnt;
    logic         vld;
    logic [1:0]   id;
    logic [N-1:0] ptr;
    logic         to;
  } exp_t;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q[$];

  int m_owner = -1;
  int m_ten   = 0;
  int m_pidx  = 0;
  logic m_to  = 1'b0;

  rr_ring_arbiter_if #(.N(N)) arb_if ();

  rr_ring_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index, tenure length and pointer index.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ten   = 0;
      m_pidx  = 0;
    end else if (m_owner >= 0) begin
      if (!arb_if.req[m_owner] || m_ten == MAX_HOLD) begin
        m_to    = arb_if.req[m_owner];
        m_pidx  = (m_owner + 1) % N;
        m_owner = -1;
        m_ten   = 0;
      end else begin
        m_ten++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int w;
        w = (m_pidx + k) % N;
        if (m_owner < 0 && arb_if.req[w]) begin
          m_owner = w;
          m_ten   = 1;
        end
      end
    end
    e.gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.vld = (m_owner >= 0);
    e.id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.ptr = N'(1 << m_pidx);
    e.to  = m_to;
    q.push_back(e);
  end

  // Monitor: pop predicted outputs and compare, plus invariants.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (arb_if.gnt !== e.gnt || arb_if.gnt_valid !== e.vld ||
          arb_if.gnt_id !== e.id || arb_if.ptr !== e.ptr ||
          arb_if.timeout !== e.to) begin
        errors++;
        $display("FAIL outputs cyc=%0d got gnt=%b v=%b id=%0d ptr=%b to=%b want gnt=%b v=%b id=%0d ptr=%b to=%b",
                 cyc, arb_if.gnt, arb_if.gnt_valid, arb_if.gnt_id,
                 arb_if.ptr, arb_if.timeout, e.gnt, e.vld, e.id,
                 e.ptr, e.to);
      end
      checks++;
      if ($countones(arb_if.ptr) != 1 ||
          $countones(arb_if.gnt) > 1 ||
          arb_if.gnt_valid !== (|arb_if.gnt)) begin
        errors++;
        $display("FAIL invariant cyc=%0d got gnt=%b v=%b ptr=%b want onehot ptr, <=1 gnt, v=|gnt",
                 cyc, arb_if.gnt, arb_if.gnt_valid, arb_if.ptr);
      end
    end
  end

  task automatic step(input logic r, input logic [N-1:0] rq);
    @(negedge clk);
    rst        = r;
    arb_if.req = rq;
  endtask

  initial begin
    logic [N-1:0] r;
    rst        = 1'b1;
    arb_if.req = 4'b1111;

    // Reset with all requesting, then first grant to 0.
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);

    // Single request held for 3 grant cycles.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    repeat (3) step(1'b0, 4'b0100);
    repeat (3) step(1'b0, 4'b0000);

    // Fairness: every owner drops for one cycle after two grant cycles.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      r = 4'b1111;
      if (m_owner >= 0 && m_ten == 2) r[m_owner] = 1'b0;
      rst        = 1'b0;
      arb_if.req = r;
    end

    // Timeout: single requester held forever.
    step(1'b1, 4'b0000);
    repeat (16) step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Wrap: ptr goes to 1000, then 0101 arrives in the gap cycle.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    repeat (12) step(1'b0, 4'b0101);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Request drops exactly on the limit edge: normal release.
    repeat (MAX_HOLD) step(1'b0, 4'b0010);
    repeat (3) step(1'b0, 4'b0000);

    // Reset mid-grant of owner 3.
    step(1'b1, 4'b0000);
    repeat (2) step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    repeat (3) step(1'b0, 4'b0000);

    // Random traffic with occasional reset.
    r = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      step(($urandom_range(0, 99) == 0), r);
    end
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL drain got %0d pending want <=1", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
